// File: rtl/ex_operand_stage.sv
// Execute-stage operand register: one-entry skid with optional result forwarding.
// Forwarding (capture-time and hold-time) is compiled only when EX_OPERAND_FWD_EN is defined.
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int NFWD = 2,
  parameter int RAW  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RAW-1:0]       rs1_addr,
  input  logic [RAW-1:0]       rs2_addr,
  input  logic [XLEN-1:0]      reg1_data,
  input  logic [XLEN-1:0]      reg2_data,
  input  logic [XLEN-1:0]      pc_val,
  input  logic [XLEN-1:0]      imm_signed,
  input  logic                 op1_sel,
  input  logic                 op2_sel,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RAW-1:0]  fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      op1,
  output logic [XLEN-1:0]      op2,
  output logic [XLEN-1:0]      pc_out
);

  logic            r_valid;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_pc;
  logic [RAW-1:0]  r_rs1;
  logic [RAW-1:0]  r_rs2;
  logic            r_sel1;
  logic            r_sel2;

  logic            w_in_ready;
  logic            w_capture;
  logic            w_drain;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;

`ifdef EX_OPERAND_FWD_EN
  // Returns {hit, data}; lower source index wins, address 0 never matches.
  function automatic logic [XLEN:0] fwd_lookup(
    input logic [RAW-1:0]       a,
    input logic [NFWD-1:0]      fv,
    input logic [NFWD*RAW-1:0]  fa,
    input logic [NFWD*XLEN-1:0] fd
  );
    logic [XLEN:0] hit;
    hit = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fv[i] && (fa[i*RAW +: RAW] == a) && (a != '0))
        hit = {1'b1, fd[i*XLEN +: XLEN]};
    end
    return hit;
  endfunction

  logic            w_hold;
  logic [XLEN:0]   w_fwd1;
  logic [XLEN:0]   w_fwd2;
  logic [XLEN:0]   w_hfwd1;
  logic [XLEN:0]   w_hfwd2;
  logic [XLEN-1:0] w_hold_op1;
  logic [XLEN-1:0] w_hold_op2;

  always_comb begin
    w_fwd1     = fwd_lookup(rs1_addr, fwd_valid, fwd_addr, fwd_data);
    w_fwd2     = fwd_lookup(rs2_addr, fwd_valid, fwd_addr, fwd_data);
    w_hfwd1    = fwd_lookup(r_rs1, fwd_valid, fwd_addr, fwd_data);
    w_hfwd2    = fwd_lookup(r_rs2, fwd_valid, fwd_addr, fwd_data);
    w_src1     = w_fwd1[XLEN] ? w_fwd1[XLEN-1:0] : reg1_data;
    w_src2     = w_fwd2[XLEN] ? w_fwd2[XLEN-1:0] : reg2_data;
    // PC/immediate operands are frozen while held; only register operands refresh.
    w_hold_op1 = (!r_sel1 && w_hfwd1[XLEN]) ? w_hfwd1[XLEN-1:0] : r_op1;
    w_hold_op2 = (!r_sel2 && w_hfwd2[XLEN]) ? w_hfwd2[XLEN-1:0] : r_op2;
  end

  assign w_hold = r_valid && !out_ready;
`else
  logic w_unused_fwd;

  assign w_src1       = reg1_data;
  assign w_src2       = reg2_data;
  assign w_unused_fwd = ^{fwd_valid, fwd_addr, fwd_data, r_rs1, r_rs2, r_sel1, r_sel2};
`endif

  assign w_in_ready = !r_valid || out_ready;
  assign w_capture  = in_valid && w_in_ready && !flush;
  assign w_drain    = r_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_pc    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_sel1  <= 1'b0;
      r_sel2  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_op1   <= op1_sel ? pc_val : w_src1;
      r_op2   <= op2_sel ? imm_signed : w_src2;
      r_pc    <= pc_val;
      r_rs1   <= rs1_addr;
      r_rs2   <= rs2_addr;
      r_sel1  <= op1_sel;
      r_sel2  <= op2_sel;
    end else if (w_drain) begin
      r_valid <= 1'b0;
`ifdef EX_OPERAND_FWD_EN
    end else if (w_hold) begin
      r_op1 <= w_hold_op1;
      r_op2 <= w_hold_op2;
`endif
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign op1       = r_op1;
  assign op2       = r_op2;
  assign pc_out    = r_pc;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed cases then random traffic vs a queue model.
// Expectations follow EX_OPERAND_FWD_EN when it is defined for the build.
module tb_ex_operand_stage;

  localparam int XLEN = 32;
  localparam int NFWD = 2;
  localparam int RAW  = 5;
`ifdef EX_OPERAND_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  typedef struct {
    bit                   iv;
    bit                   fl;
    bit                   ordy;
    logic [RAW-1:0]       rs1;
    logic [RAW-1:0]       rs2;
    logic [XLEN-1:0]      r1;
    logic [XLEN-1:0]      r2;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    bit                   s1;
    bit                   s2;
    logic [NFWD-1:0]      fv;
    logic [NFWD*RAW-1:0]  fa;
    logic [NFWD*XLEN-1:0] fd;
  } stim_t;

  typedef struct {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] pc;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    bit              s1;
    bit              s2;
  } exp_t;

  logic                 clk, rst, flush, in_valid, in_ready;
  logic [RAW-1:0]       rs1_addr, rs2_addr;
  logic [XLEN-1:0]      reg1_data, reg2_data, pc_val, imm_signed;
  logic                 op1_sel, op2_sel;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD*RAW-1:0]  fwd_addr;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 out_valid, out_ready;
  logic [XLEN-1:0]      op1, op2, pc_out;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ex_operand_stage #(.XLEN(XLEN), .NFWD(NFWD), .RAW(RAW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .reg1_data(reg1_data), .reg2_data(reg2_data),
    .pc_val(pc_val), .imm_signed(imm_signed), .op1_sel(op1_sel), .op2_sel(op2_sel),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2), .pc_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rule: a register operand takes the first valid source naming it, never for x0.
  function automatic logic [XLEN-1:0] resolve(input logic [RAW-1:0] a, input logic [XLEN-1:0] rd,
                                              input stim_t s);
    if (FWD_ON && a != 0)
      for (int i = 0; i < NFWD; i++)
        if (s.fv[i] && s.fa[i*RAW +: RAW] == a) return s.fd[i*XLEN +: XLEN];
    return rd;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    flush = s.fl; in_valid = s.iv; out_ready = s.ordy;
    rs1_addr = s.rs1; rs2_addr = s.rs2; reg1_data = s.r1; reg2_data = s.r2;
    pc_val = s.pc; imm_signed = s.imm; op1_sel = s.s1; op2_sel = s.s2;
    fwd_valid = s.fv; fwd_addr = s.fa; fwd_data = s.fd;
  endtask

  // Drives one cycle of stimulus and records what the stage must hold after the next edge.
  task automatic drive(input stim_t s);
    bit   held, rdy;
    exp_t e;
    @(negedge clk); #1;
    apply(s);
    rst = 1'b0;
    #1;
    held = (exp_q.size() != 0);
    rdy  = !held || s.ordy;
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    if (s.fl) begin
      exp_q.delete();
    end else if (s.iv && rdy) begin
      if (held) void'(exp_q.pop_front());
      e.op1 = s.s1 ? s.pc  : resolve(s.rs1, s.r1, s);
      e.op2 = s.s2 ? s.imm : resolve(s.rs2, s.r2, s);
      e.pc  = s.pc; e.rs1 = s.rs1; e.rs2 = s.rs2; e.s1 = s.s1; e.s2 = s.s2;
      exp_q.push_back(e);
    end else if (held && s.ordy) begin
      void'(exp_q.pop_front());
    end else if (held) begin
      if (!exp_q[0].s1) exp_q[0].op1 = resolve(exp_q[0].rs1, exp_q[0].op1, s);
      if (!exp_q[0].s2) exp_q[0].op2 = resolve(exp_q[0].rs2, exp_q[0].op2, s);
    end
  endtask

  // Monitor: compares the presented entry against the scoreboard head every cycle.
  initial begin
    forever begin
      @(negedge clk);
      chk("mon_out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0 && out_valid) begin
        chk("mon_op1", op1, exp_q[0].op1);
        chk("mon_op2", op2, exp_q[0].op2);
        chk("mon_pc_out", pc_out, exp_q[0].pc);
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    apply(idle());
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_op1", op1, 32'h0);
    chk("rst_op2", op2, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    @(negedge clk);

    // register op1, immediate op2; capture on the first edge after reset release
    s = idle(); s.iv = 1; s.rs1 = 5'd1; s.r1 = 32'h10; s.s2 = 1; s.imm = 32'hFFFF_FFFC; s.pc = 32'h100;
    drive(s);
    s = idle(); s.ordy = 1;
    drive(s);
    chk("basic_valid", {31'b0, out_valid}, 32'h1);
    chk("basic_op1", op1, 32'h10);
    chk("basic_op2", op2, 32'hFFFF_FFFC);

    // two sources match rs1; source 0 has priority
    s = idle(); s.iv = 1; s.ordy = 1; s.rs1 = 5'd5; s.r1 = 32'h3; s.fv = 2'b11;
    s.fa = {5'd5, 5'd5}; s.fd = {32'hBB, 32'hAA};
    drive(s);
    s = idle(); s.ordy = 1;
    drive(s);
    chk("fwd_prio_op1", op1, FWD_ON ? 32'hAA : 32'h3);

    // x0 is never forwarded
    s = idle(); s.iv = 1; s.ordy = 1; s.rs2 = 5'd0; s.r2 = 32'h0; s.fv = 2'b01;
    s.fa = {5'd0, 5'd0}; s.fd = {32'h0, 32'h55};
    drive(s);
    s = idle(); s.ordy = 1;
    drive(s);
    chk("x0_op2", op2, 32'h0);

    // held entry refreshes its register operand, immediate stays
    s = idle(); s.iv = 1; s.rs1 = 5'd7; s.r1 = 32'h1; s.s2 = 1; s.imm = 32'h777; s.pc = 32'h40;
    drive(s);
    s = idle(); s.fv = 2'b10; s.fa = {5'd7, 5'd0}; s.fd = {32'h1234, 32'h0};
    drive(s);
    s = idle();
    drive(s);
    chk("hold_op1", op1, FWD_ON ? 32'h1234 : 32'h1);
    chk("hold_op2", op2, 32'h777);

    // flush beats simultaneous drain and capture
    s = idle(); s.iv = 1; s.ordy = 1; s.fl = 1; s.r1 = 32'h99;
    drive(s);
    s = idle();
    drive(s);
    chk("flush_valid", {31'b0, out_valid}, 32'h0);

    // reset in the middle of a hold clears everything without a clock edge
    s = idle(); s.iv = 1; s.r1 = 32'h55; s.r2 = 32'h66; s.pc = 32'h200;
    drive(s);
    s = idle();
    drive(s);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    @(negedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_op1", op1, 32'h0);
    chk("midrst_op2", op2, 32'h0);
    chk("midrst_pc_out", pc_out, 32'h0);
    @(posedge clk);

    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.iv   = ($urandom_range(0, 9) < 7);
      s.ordy = ($urandom_range(0, 9) < 6);
      s.fl   = ($urandom_range(0, 19) == 0);
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.r1   = $urandom(); s.r2 = $urandom(); s.pc = $urandom(); s.imm = $urandom();
      s.s1   = $urandom_range(0, 1) != 0;
      s.s2   = $urandom_range(0, 1) != 0;
      s.fv   = 2'($urandom_range(0, 3));
      s.fa   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      s.fd   = {$urandom(), $urandom()};
      drive(s);
    end

    s = idle(); s.ordy = 1;
    drive(s);
    drive(s);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
